// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch BCD time counter.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam int NUM_DIGITS = 6;

    // Index 0 is the centisecond units digit, index 5 the minute tens digit.
    localparam bcd_t DIGIT_MAX [NUM_DIGITS-1:0] = '{4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    localparam int CS0  = 0;
    localparam int CS1  = 1;
    localparam int SEC0 = 2;
    localparam int SEC1 = 3;
    localparam int MIN0 = 4;
    localparam int MIN1 = 5;

endpackage

// File: rtl/stopwatch_core_bcd_digit_cnt.sv
// One BCD digit of the time counter: counts 0..MAX on inc, carries out at MAX.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t value,
    output logic carry
);

    // Values above MAX are unreachable; treating them like MAX recovers to 0.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value >= MAX) ? '0 : value + 4'd1;
        end
    end

    assign carry = inc && (value == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timebase and MM:SS.cc BCD counter feeding the HEX5..HEX0 decoders.
// Optional lap hold is built when STOPWATCH_LAP_EN is defined.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_stop,
    input  logic                       clear,
    input  logic                       lap,
    output logic [NUM_DIGITS-1:0][3:0] digits,
    output logic                       running,
    output logic                       frozen,
    output logic                       wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    if (((CLK_HZ % TICK_HZ) != 0) || (DIV < 2)) begin : g_bad_div
        $error("stopwatch_core: CLK_HZ/TICK_HZ must be an integer of at least 2");
    end

    logic [PW-1:0]                presc;
    logic                         tick;
    logic [NUM_DIGITS-1:0][3:0]   live;

    assign tick = running && (presc == PRESC_LAST);

    // Prescaler only advances while running, so a stop keeps the partial tick.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            presc <= '0;
        end else if (running) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            running <= 1'b0;
        end else if (start_stop) begin
            running <= ~running;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        logic inc;
        logic carry;

        if (i == CS0) begin : g_first
            assign inc = tick;
        end else begin : g_chain
            assign inc = g_dig[i-1].carry;
        end

        bcd_digit_cnt #(.MAX(DIGIT_MAX[i])) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .clr  (clear),
            .inc  (inc),
            .value(live[i]),
            .carry(carry)
        );
    end

    // Carry out of the minute tens digit means every digit has just rolled to 0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wrap <= 1'b0;
        end else begin
            wrap <= g_dig[MIN1].carry;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [NUM_DIGITS-1:0][3:0] snap;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            frozen <= 1'b0;
            snap   <= '0;
        end else if (lap) begin
            if (frozen) begin
                frozen <= 1'b0;
            end else if (running) begin
                frozen <= 1'b1;
                snap   <= live;
            end
        end
    end

    assign digits = frozen ? snap : live;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign frozen     = 1'b0;
    assign digits     = live;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core at DIV=4: tick-count reference model plus directed literal checks.
module tb_stopwatch_core;

    localparam int DIV   = 4;
    localparam int TOTAL = 360000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_stop = 1'b0;
    logic            clear = 1'b0;
    logic            lap = 1'b0;
    logic [5:0][3:0] digits;
    logic            running;
    logic            frozen;
    logic            wrap;

    stopwatch_core #(.CLK_HZ(4), .TICK_HZ(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .clear     (clear),
        .lap       (lap),
        .digits    (digits),
        .running   (running),
        .frozen    (frozen),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Reference model: elapsed time as a plain tick count
    int m_count = 0;
    int m_phase = 0;
    int m_snap  = 0;
    bit m_run = 1'b0, m_frozen = 1'b0, m_wrap = 1'b0;

    bit          chk_en = 1'b0;
    bit          preload = 1'b0;
    int          preload_val = 0;
    logic [23:0] pre_dig = '0;

    bit          lit_req = 1'b0;
    string       lit_name = "";
    logic [23:0] lit_dig = '0;
    bit          lit_run = 1'b0, lit_frz = 1'b0, lit_wrap = 1'b0;

    function automatic logic [23:0] to_bcd(int c);
        logic [23:0] r;
        r[3:0]   = 4'(c % 10);
        r[7:4]   = 4'((c / 10) % 10);
        r[11:8]  = 4'((c / 100) % 10);
        r[15:12] = 4'((c / 1000) % 6);
        r[19:16] = 4'((c / 6000) % 10);
        r[23:20] = 4'(c / 60000);
        return r;
    endfunction

    always @(posedge clk) begin
        bit tk;
        int nxt;
        tk = m_run && (m_phase == DIV - 1);
        if (rst) begin
            m_count = 0; m_phase = 0; m_snap = 0;
            m_run = 1'b0; m_frozen = 1'b0; m_wrap = 1'b0;
        end else if (clear) begin
            m_count = 0; m_phase = 0;
            m_run = 1'b0; m_frozen = 1'b0; m_wrap = 1'b0;
        end else begin
            m_wrap = tk && (m_count == TOTAL - 1);
            nxt = tk ? (m_count + 1) % TOTAL : m_count;
`ifdef STOPWATCH_LAP_EN
            if (lap) begin
                if (m_frozen) begin
                    m_frozen = 1'b0;
                end else if (m_run) begin
                    m_frozen = 1'b1;
                    m_snap = m_count;
                end
            end
`endif
            if (m_run) m_phase = tk ? 0 : m_phase + 1;
            if (start_stop) m_run = !m_run;
            m_count = nxt;
        end
        if (preload) m_count = preload_val;
    end

    task automatic cmp(input string n, input logic [23:0] act, input logic [23:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("digits", digits, m_frozen ? to_bcd(m_snap) : to_bcd(m_count));
            cmp("running", 24'(running), 24'(m_run));
            cmp("frozen", 24'(frozen), 24'(m_frozen));
            cmp("wrap", 24'(wrap), 24'(m_wrap));
        end
        if (lit_req) begin
            cmp({lit_name, " digits"}, digits, lit_dig);
            cmp({lit_name, " running"}, 24'(running), 24'(lit_run));
            cmp({lit_name, " frozen"}, 24'(frozen), 24'(lit_frz));
            cmp({lit_name, " wrap"}, 24'(wrap), 24'(lit_wrap));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cyc();
        start_stop = 1'b0;
    endtask

    task automatic expect_lit(input string n, input logic [23:0] d, input bit r, input bit f, input bit w);
        lit_name = n; lit_dig = d; lit_run = r; lit_frz = f; lit_wrap = w;
        lit_req = 1'b1;
        @(negedge clk);
        #1;
        lit_req = 1'b0;
    endtask

    // Counting to a late time takes too long, so the digit registers are loaded while stopped.
    task automatic do_preload(input int c);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk_en = 1'b0;
        pre_dig = to_bcd(c);
        force dut.g_dig[0].u_cnt.value = pre_dig[3:0];
        force dut.g_dig[1].u_cnt.value = pre_dig[7:4];
        force dut.g_dig[2].u_cnt.value = pre_dig[11:8];
        force dut.g_dig[3].u_cnt.value = pre_dig[15:12];
        force dut.g_dig[4].u_cnt.value = pre_dig[19:16];
        force dut.g_dig[5].u_cnt.value = pre_dig[23:20];
        preload_val = c;
        preload = 1'b1;
        cyc();
        release dut.g_dig[0].u_cnt.value;
        release dut.g_dig[1].u_cnt.value;
        release dut.g_dig[2].u_cnt.value;
        release dut.g_dig[3].u_cnt.value;
        release dut.g_dig[4].u_cnt.value;
        release dut.g_dig[5].u_cnt.value;
        preload = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        repeat (2) cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        expect_lit("reset", 24'h000000, 1'b0, 1'b0, 1'b0);

        pulse_ss();
        expect_lit("start", 24'h000000, 1'b1, 1'b0, 1'b0);
        repeat (40) cyc();
        expect_lit("tenth tick", 24'h000010, 1'b1, 1'b0, 1'b0);

        // Stop mid-period: prescaler is held at 3, so one cycle after restart gives a tick
        repeat (2) cyc();
        pulse_ss();
        expect_lit("stopped", 24'h000010, 1'b0, 1'b0, 1'b0);
        repeat (20) cyc();
        pulse_ss();
        expect_lit("restart", 24'h000010, 1'b1, 1'b0, 1'b0);
        cyc();
        expect_lit("partial tick kept", 24'h000011, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            start_stop = ($urandom_range(0, 7) == 0);
            clear      = ($urandom_range(0, 99) == 0);
            lap        = ($urandom_range(0, 9) == 0);
            rst        = ($urandom_range(0, 799) == 0);
            cyc();
        end
        start_stop = 1'b0; clear = 1'b0; lap = 1'b0; rst = 1'b0;

        do_preload(359998);
        expect_lit("preload", 24'h595998, 1'b0, 1'b0, 1'b0);
        pulse_ss();
        repeat (8) cyc();
        expect_lit("wrap", 24'h000000, 1'b1, 1'b0, 1'b1);
        cyc();
        expect_lit("after wrap", 24'h000000, 1'b1, 1'b0, 1'b0);

        do_preload(1234);
        pulse_ss();
        repeat (3) cyc();
        start_stop = 1'b1;
        clear = 1'b1;
        cyc();
        start_stop = 1'b0;
        clear = 1'b0;
        expect_lit("clear beats start_stop", 24'h000000, 1'b0, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_EN
        pulse_ss();
        repeat (20) cyc();
        lap = 1'b1;
        cyc();
        lap = 1'b0;
        expect_lit("lap freeze", 24'h000005, 1'b1, 1'b1, 1'b0);
        repeat (59) cyc();
        expect_lit("lap hold", 24'h000005, 1'b1, 1'b1, 1'b0);
        lap = 1'b1;
        cyc();
        lap = 1'b0;
        expect_lit("lap release", 24'h000020, 1'b1, 1'b0, 1'b0);
`endif

        do_preload(307);
        pulse_ss();
`ifdef STOPWATCH_LAP_EN
        lap = 1'b1;
        cyc();
        lap = 1'b0;
`endif
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        expect_lit("reset mid-count", 24'h000000, 1'b0, 1'b0, 1'b0);
        pulse_ss();
        repeat (8) cyc();
        expect_lit("count after reset", 24'h000002, 1'b1, 1'b0, 1'b0);

        repeat (4) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
